onchip_mem_arbiter: RTL and testbench
=====================================

Name: onchip_mem_arbiter

Overview:
- Two-master arbiter that shares one single-port on-chip RAM slave: 1024 x 32, byte enables, registered address, unregistered q, so read data appears 1 cycle after the address.
- Sits between two Avalon-MM masters (e.g. CPU data master and a DMA) and the RAM.
- Provides round-robin arbitration with a bounded hold, a fixed 1-cycle pipelined read return and a saturating contention counter.

Parameters:
- ADDR_W, 10, word address width (RAM depth 2^ADDR_W).
- DATA_W, 32, data width.
- BE_W, 4, byte-enable width (DATA_W/8).
- MAX_HOLD, 4, max consecutive grants to one master while the other is requesting (1 = pure round-robin); range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- m0_address  in  ADDR_W  master 0 word address.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_byteenable  in  BE_W  master 0 write byte lanes.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_waitrequest  out  1  master 0 stall.
- m0_readdata  out  DATA_W  master 0 read data.
- m0_readdatavalid  out  1  master 0 read data valid.
- m1_*  same set as m0_*  master 1.
- mem_address  out  ADDR_W  RAM address.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write.
- mem_byteenable  out  BE_W  RAM byte enables.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable; constant 1.
- mem_readdata  in  DATA_W  RAM q.
- contention_cnt  out  16  cycles in which both masters requested; saturating.

Behaviour:
- Request: req_i = mi_read | mi_write. If mi_read and mi_write are both high, the access is a write and the read is ignored.
- State registers and reset values:
  - last (1b): most recently granted master, reset 1, so m0 wins the first tie.
  - run (4b): consecutive grants to last, reset 0.
  - rd_pend (1b), reset 0.
  - rd_tag (1b), reset 0.
  - contention_cnt, reset 0.
- Grant is combinational, at most one per cycle; no grant while reset_n = 0.
  - Only one master requests: grant it.
  - Both request and 1 <= run < MAX_HOLD: grant last.
  - Both request, otherwise: grant ~last.
- Register update every clock edge:
  - Grant g == last: run <= min(run+1, MAX_HOLD).
  - Grant g != last: run <= 1, last <= g.
  - No grant: run <= 0, last unchanged.
- Waitrequest: mi_waitrequest = req_i & ~grant_i, combinational. A granted access is accepted in that same cycle.
- RAM drive, combinational from the granted master:
  - mem_address = granted address; mem_chipselect = any grant; mem_write = grant & write; mem_writedata = granted write data.
  - mem_byteenable = granted byteenable for writes, all-ones for reads.
  - With no grant, all RAM outputs except mem_clken are 0.
- Read return:
  - On a granted read: rd_pend <= 1, rd_tag <= g; otherwise rd_pend <= 0.
  - mi_readdatavalid = rd_pend & (rd_tag == i), registered, reset 0.
  - m0_readdata = m1_readdata = mem_readdata, unregistered passthrough.
  - Latency is exactly 1 cycle after acceptance. Back-to-back reads give 1 word per cycle, including alternating masters.
- Writes have no response. A write followed next cycle by a read of the same address from either master returns the new data. No same-cycle read/write conflict is possible.
- contention_cnt increments by 1 each cycle with req_0 & req_1 and holds at 0xFFFF.
- Reset asserted mid-operation: an in-flight read is dropped (readdatavalid forced 0), all state returns to reset values, and no grant is issued until reset_n is released.
- Target size: about 150-250 lines of RTL.

Test Plan:
- Reset, then m0 reads address 0x005 (RAM preloaded 0xA5A5_0005) -> m0_waitrequest 0 in the request cycle; exactly 1 cycle later m0_readdatavalid = 1 with m0_readdata = 0xA5A5_0005, m1_readdatavalid = 0.
- m0 writes 0x1234_5678 to 0x3FF with byteenable 0x3, then reads 0x3FF (prior content 0xFFFF_FFFF) -> readdata 0xFFFF_5678 one cycle after the read grant.
- MAX_HOLD = 4, both masters request reads continuously from the same cycle after reset -> grant sequence m0 x4, m1 x4, m0 x4. The waitrequest of the non-granted master is high on each cycle. readdatavalid pulses follow the grants delayed by 1 cycle. contention_cnt = 12 after 12 cycles.
- MAX_HOLD = 1, both request -> grants alternate m0, m1, m0, … every cycle. No readdatavalid is lost or misrouted.
- Read granted to m1, then reset_n pulled low for 1 cycle before the return cycle -> m1_readdatavalid stays 0 and contention_cnt = 0. After release, first tie is granted to m0.
- Force contention for 70000 cycles -> contention_cnt saturates at 0xFFFF and does not wrap.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of one single-port on-chip RAM.
// Round-robin with bounded hold, 1-cycle read return, contention counter.
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int BE_W     = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [15:0]       contention_cnt
);

  localparam logic [3:0] HOLD = 4'(MAX_HOLD);

  logic       req0;
  logic       req1;
  logic       last;
  logic [3:0] run;
  logic       rd_pend;
  logic       rd_tag;
  logic       keep;
  logic       gnt0;
  logic       gnt1;
  logic       any;
  logic       sel;
  logic       wr;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign keep = (run != 4'd0) && (run < HOLD);

  // Grants are gated by reset_n so nothing reaches the RAM while in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      unique case (1'b1)
        (req0 & ~req1): gnt0 = 1'b1;
        (req1 & ~req0): gnt1 = 1'b1;
        (req0 & req1): begin
          gnt1 = keep ? last : ~last;
          gnt0 = ~gnt1;
        end
        default: ;
      endcase
    end
  end

  assign any = gnt0 | gnt1;
  assign sel = gnt1;
  assign wr  = sel ? m1_write : m0_write;

  assign m0_waitrequest = req0 & ~gnt0;
  assign m1_waitrequest = req1 & ~gnt1;

  always_comb begin
    mem_address    = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    if (any) begin
      mem_address    = sel ? m1_address : m0_address;
      mem_chipselect = 1'b1;
      mem_write      = wr;
      mem_writedata  = sel ? m1_writedata : m0_writedata;
      if (wr)
        mem_byteenable = sel ? m1_byteenable : m0_byteenable;
      else
        mem_byteenable = '1;
    end
  end

  assign mem_clken = 1'b1;

  assign m0_readdata = mem_readdata;
  assign m1_readdata = mem_readdata;

  assign m0_readdatavalid = rd_pend & ~rd_tag;
  assign m1_readdatavalid = rd_pend & rd_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last           <= 1'b1;
      run            <= 4'd0;
      rd_pend        <= 1'b0;
      rd_tag         <= 1'b0;
      contention_cnt <= 16'd0;
    end else begin
      if (!any) begin
        run <= 4'd0;
      end else if (sel == last) begin
        run <= (run >= HOLD) ? HOLD : run + 4'd1;
      end else begin
        run  <= 4'd1;
        last <= sel;
      end
      rd_pend <= any & ~wr;
      if (any & ~wr)
        rd_tag <= sel;
      if (req0 && req1 && contention_cnt != 16'hFFFF)
        contention_cnt <= contention_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench: two arbiters (MAX_HOLD 4 and 1) share master stimulus,
// each with its own behavioural RAM (registered address, raw q).
module tb_onchip_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [9:0]  m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] m0_writedata, m1_writedata;

  logic        a_w0, a_w1, a_v0, a_v1, a_cs, a_we, a_ck;
  logic [31:0] a_d0, a_d1, a_wd, a_q;
  logic [9:0]  a_addr;
  logic [3:0]  a_be;
  logic [15:0] a_cnt;

  logic        b_w0, b_w1, b_v0, b_v1, b_cs, b_we, b_ck;
  logic [31:0] b_d0, b_d1, b_wd, b_q;
  logic [9:0]  b_addr;
  logic [3:0]  b_be;
  logic [15:0] b_cnt;

  logic [31:0] ram_a [1024];
  logic [31:0] ram_b [1024];
  logic [9:0]  ra_a, ra_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(a_w0), .m0_readdata(a_d0), .m0_readdatavalid(a_v0),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(a_w1), .m1_readdata(a_d1), .m1_readdatavalid(a_v1),
    .mem_address(a_addr), .mem_chipselect(a_cs), .mem_write(a_we),
    .mem_byteenable(a_be), .mem_writedata(a_wd), .mem_clken(a_ck),
    .mem_readdata(a_q), .contention_cnt(a_cnt)
  );

  onchip_mem_arbiter #(.MAX_HOLD(1)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(b_w0), .m0_readdata(b_d0), .m0_readdatavalid(b_v0),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(b_w1), .m1_readdata(b_d1), .m1_readdatavalid(b_v1),
    .mem_address(b_addr), .mem_chipselect(b_cs), .mem_write(b_we),
    .mem_byteenable(b_be), .mem_writedata(b_wd), .mem_clken(b_ck),
    .mem_readdata(b_q), .contention_cnt(b_cnt)
  );

  assign a_q = ram_a[ra_a];
  assign b_q = ram_b[ra_b];

  always @(posedge clk) begin
    if (a_ck) begin
      ra_a <= a_addr;
      if (a_cs && a_we)
        for (int i = 0; i < 4; i++)
          if (a_be[i]) ram_a[a_addr][8*i +: 8] <= a_wd[8*i +: 8];
    end
    if (b_ck) begin
      ra_b <= b_addr;
      if (b_cs && b_we)
        for (int i = 0; i < 4; i++)
          if (b_be[i]) ram_b[b_addr][8*i +: 8] <= b_wd[8*i +: 8];
    end
  end

  function automatic logic [31:0] pat(input int a);
    return 32'hA5A5_0000 | 32'(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ram_a[i] = pat(i);
      ram_b[i] = pat(i);
    end
    ram_a[10'h3FF] = 32'hFFFF_FFFF;
    ram_b[10'h3FF] = 32'hFFFF_FFFF;
    ra_a = '0; ra_b = '0;
    m0_address = '0; m1_address = '0;
    m0_byteenable = '0; m1_byteenable = '0;
    m0_writedata = '0; m1_writedata = '0;
    idle();
    reset_n = 0;

    // reset: requests present but no grant
    m0_read = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wait0", a_w0, 1);
    chk("rst_cs", a_cs, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_v0", a_v0, 0);
    chk("rst_clken", a_ck, 1);
    idle();
    @(negedge clk);
    reset_n = 1;

    // single read from m0
    @(negedge clk);
    m0_read = 1; m0_address = 10'h005;
    #1;
    chk("rd_wait0", a_w0, 0);
    chk("rd_cs", a_cs, 1);
    chk("rd_addr", a_addr, 10'h005);
    chk("rd_be", a_be, 4'hF);
    @(negedge clk);
    idle();
    #1;
    chk("rd_v0", a_v0, 1);
    chk("rd_data", a_d0, 32'hA5A5_0005);
    chk("rd_v1", a_v1, 0);
    @(negedge clk);
    #1;
    chk("rd_v0_off", a_v0, 0);

    // partial write then readback
    m0_write = 1; m0_address = 10'h3FF;
    m0_byteenable = 4'h3; m0_writedata = 32'h1234_5678;
    #1;
    chk("wr_we", a_we, 1);
    chk("wr_be", a_be, 4'h3);
    chk("wr_wd", a_wd, 32'h1234_5678);
    @(negedge clk);
    m0_write = 0; m0_read = 1;
    #1;
    chk("wr_v0", a_v0, 0);
    chk("rb_wait0", a_w0, 0);
    @(negedge clk);
    idle();
    #1;
    chk("rb_v0", a_v0, 1);
    chk("rb_data", a_d0, 32'hFFFF_5678);

    // read+write together is a write
    @(negedge clk);
    m1_read = 1; m1_write = 1; m1_address = 10'h200;
    m1_byteenable = 4'hF; m1_writedata = 32'hDEAD_BEEF;
    #1;
    chk("rw_we", a_we, 1);
    chk("rw_wait1", a_w1, 0);
    @(negedge clk);
    idle();
    #1;
    chk("rw_v1", a_v1, 0);

    // contention from reset: MAX_HOLD 4 on a, 1 on b
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      if (k < 12) begin
        m0_read = 1; m1_read = 1;
        m0_address = 10'(k); m1_address = 10'(256 + k);
      end else begin
        idle();
      end
      #1;
      if (k < 12) begin
        chk("ca_w0", a_w0, ((k / 4) % 2) == 1);
        chk("ca_w1", a_w1, ((k / 4) % 2) == 0);
        chk("cb_w0", b_w0, (k % 2) == 1);
        chk("cb_w1", b_w1, (k % 2) == 0);
      end
      if (k > 0) begin
        chk("ca_v0", a_v0, (((k - 1) / 4) % 2) == 0);
        chk("ca_v1", a_v1, (((k - 1) / 4) % 2) == 1);
        chk("ca_d", a_d0,
            pat((((k - 1) / 4) % 2) == 1 ? 256 + k - 1 : k - 1));
        chk("cb_v0", b_v0, ((k - 1) % 2) == 0);
        chk("cb_v1", b_v1, ((k - 1) % 2) == 1);
        chk("cb_d", b_d1,
            pat(((k - 1) % 2) == 1 ? 256 + k - 1 : k - 1));
      end
    end
    chk("ca_cnt12", a_cnt, 12);
    chk("cb_cnt12", b_cnt, 12);

    // m1 read in flight, reset before its return cycle
    @(negedge clk);
    m1_read = 1; m1_address = 10'h020;
    #1;
    chk("mr_wait1", a_w1, 0);
    @(posedge clk);
    #1;
    reset_n = 0;
    idle();
    #1;
    chk("mr_v1", a_v1, 0);
    @(posedge clk);
    #1;
    reset_n = 1;
    @(negedge clk);
    #1;
    chk("mr_v1_post", a_v1, 0);
    chk("mr_cnt", a_cnt, 0);
    m0_read = 1; m1_read = 1;
    #1;
    chk("mr_tie_w0", a_w0, 0);
    chk("mr_tie_w1", a_w1, 1);

    // saturation of the contention counter
    @(negedge clk);
    idle();
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    m0_read = 1; m1_read = 1;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", a_cnt, 16'hFFFE);
    @(posedge clk);
    #1;
    chk("sat_ffff", a_cnt, 16'hFFFF);
    repeat (4465) @(posedge clk);
    #1;
    chk("sat_hold", a_cnt, 16'hFFFF);
    chk("sat_hold_b", b_cnt, 16'hFFFF);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
